// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/note-off events onto a fixed pool of
// synth voices, keeping a per-voice age rank so the oldest voice can be stolen.
module voice_allocator #(
   parameter int NUM_VOICES     = 8,
   parameter int NOTE_WIDTH     = 7,
   parameter int VELOCITY_WIDTH = 7
) (
   input  logic                                 clock_50_000_000,
   input  logic                                 reset_l,
   input  logic                                 event_valid,
   output logic                                 event_ready,
   input  logic                                 event_is_on,
   input  logic [NOTE_WIDTH-1:0]                event_note,
   input  logic [VELOCITY_WIDTH-1:0]            event_velocity,
   input  logic                                 all_notes_off,
   output logic [NUM_VOICES-1:0]                voice_active,
   output logic [NUM_VOICES*NOTE_WIDTH-1:0]     voice_note,
   output logic [NUM_VOICES*VELOCITY_WIDTH-1:0] voice_velocity,
   output logic [NUM_VOICES-1:0]                voice_trigger,
   output logic                                 voice_stolen,
   output logic [$clog2(NUM_VOICES):0]          active_count
);

   localparam int AW = $clog2(NUM_VOICES);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] { IDLE, LOOKUP, UPDATE } state_t;

   state_t                    state_q, state_d;
   logic                      ready_q, ready_d;
   logic                      ev_on_q, ev_on_d;
   logic [NOTE_WIDTH-1:0]     ev_note_q, ev_note_d;
   logic [VELOCITY_WIDTH-1:0] ev_vel_q, ev_vel_d;
   logic                      match_hit_q, match_hit_d;
   logic [AW-1:0]             match_idx_q, match_idx_d;
   logic                      free_hit_q, free_hit_d;
   logic [AW-1:0]             free_idx_q, free_idx_d;
   logic [AW-1:0]             oldest_idx_q, oldest_idx_d;
   logic [NUM_VOICES-1:0]     active_q, active_d;
   logic [NOTE_WIDTH-1:0]     note_q [NUM_VOICES];
   logic [NOTE_WIDTH-1:0]     note_d [NUM_VOICES];
   logic [VELOCITY_WIDTH-1:0] vel_q [NUM_VOICES];
   logic [VELOCITY_WIDTH-1:0] vel_d [NUM_VOICES];
   logic [AW-1:0]             age_q [NUM_VOICES];
   logic [AW-1:0]             age_d [NUM_VOICES];
   logic [NUM_VOICES-1:0]     trigger_q, trigger_d;
   logic                      stolen_q, stolen_d;
   logic [CW-1:0]             count_q, count_d;

   logic                      look_match;
   logic [AW-1:0]             look_match_idx;
   logic                      look_free;
   logic [AW-1:0]             look_free_idx;
   logic [AW-1:0]             look_oldest_idx;
   logic [AW-1:0]             oldest_age;
   logic [AW-1:0]             tgt;
   logic [AW-1:0]             tgt_age;
   logic                      tgt_was_free;

   // Descending scan so the lowest-index hit wins; the oldest voice holds rank count-1.
   always_comb begin
      oldest_age      = AW'(count_q - CW'(1));
      look_match      = 1'b0;
      look_match_idx  = '0;
      look_free       = 1'b0;
      look_free_idx   = '0;
      look_oldest_idx = '0;
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         if (active_q[v] && (note_q[v] == ev_note_q)) begin
            look_match     = 1'b1;
            look_match_idx = AW'(v);
         end
         if (!active_q[v]) begin
            look_free     = 1'b1;
            look_free_idx = AW'(v);
         end
         if (active_q[v] && (age_q[v] == oldest_age)) begin
            look_oldest_idx = AW'(v);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      ev_on_d      = ev_on_q;
      ev_note_d    = ev_note_q;
      ev_vel_d     = ev_vel_q;
      match_hit_d  = match_hit_q;
      match_idx_d  = match_idx_q;
      free_hit_d   = free_hit_q;
      free_idx_d   = free_idx_q;
      oldest_idx_d = oldest_idx_q;
      active_d     = active_q;
      note_d       = note_q;
      vel_d        = vel_q;
      age_d        = age_q;
      count_d      = count_q;
      trigger_d    = '0;
      stolen_d     = 1'b0;
      tgt          = '0;
      tgt_age      = '0;
      tgt_was_free = 1'b0;

      case (state_q)
         IDLE: begin
            if (event_valid && event_ready) begin
               ev_on_d   = event_is_on && (event_velocity != '0);
               ev_note_d = event_note;
               ev_vel_d  = event_velocity;
               state_d   = LOOKUP;
            end
         end
         LOOKUP: begin
            match_hit_d  = look_match;
            match_idx_d  = look_match_idx;
            free_hit_d   = look_free;
            free_idx_d   = look_free_idx;
            oldest_idx_d = look_oldest_idx;
            state_d      = UPDATE;
         end
         UPDATE: begin
            state_d = IDLE;
            if (ev_on_q) begin
               if (match_hit_q) begin
                  tgt = match_idx_q;
               end else if (free_hit_q) begin
                  tgt          = free_idx_q;
                  tgt_was_free = 1'b1;
               end else begin
                  tgt      = oldest_idx_q;
                  stolen_d = 1'b1;
               end
               tgt_age = age_q[tgt];
               // A free target has no rank yet, so every active voice ages by one.
               for (int v = 0; v < NUM_VOICES; v++) begin
                  if (active_q[v] && (AW'(v) != tgt) && (tgt_was_free || (age_q[v] < tgt_age))) begin
                     age_d[v] = age_q[v] + AW'(1);
                  end
               end
               active_d[tgt]  = 1'b1;
               note_d[tgt]    = ev_note_q;
               vel_d[tgt]     = ev_vel_q;
               age_d[tgt]     = '0;
               trigger_d[tgt] = 1'b1;
               if (tgt_was_free) begin
                  count_d = count_q + CW'(1);
               end
            end else if (match_hit_q) begin
               tgt     = match_idx_q;
               tgt_age = age_q[tgt];
               for (int v = 0; v < NUM_VOICES; v++) begin
                  if (active_q[v] && (age_q[v] > tgt_age)) begin
                     age_d[v] = age_q[v] - AW'(1);
                  end
               end
               active_d[tgt] = 1'b0;
               age_d[tgt]    = '0;
               count_d       = count_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Panic clear beats any event that is in flight this cycle.
      if (all_notes_off) begin
         state_d   = IDLE;
         active_d  = '0;
         trigger_d = '0;
         stolen_d  = 1'b0;
         count_d   = '0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            age_d[v] = '0;
         end
      end

      ready_d = (state_d == IDLE) && !all_notes_off;
   end

   always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
      if (!reset_l) begin
         state_q      <= IDLE;
         ready_q      <= 1'b0;
         ev_on_q      <= 1'b0;
         ev_note_q    <= '0;
         ev_vel_q     <= '0;
         match_hit_q  <= 1'b0;
         match_idx_q  <= '0;
         free_hit_q   <= 1'b0;
         free_idx_q   <= '0;
         oldest_idx_q <= '0;
         active_q     <= '0;
         trigger_q    <= '0;
         stolen_q     <= 1'b0;
         count_q      <= '0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            note_q[v] <= '0;
            vel_q[v]  <= '0;
            age_q[v]  <= '0;
         end
      end else begin
         state_q      <= state_d;
         ready_q      <= ready_d;
         ev_on_q      <= ev_on_d;
         ev_note_q    <= ev_note_d;
         ev_vel_q     <= ev_vel_d;
         match_hit_q  <= match_hit_d;
         match_idx_q  <= match_idx_d;
         free_hit_q   <= free_hit_d;
         free_idx_q   <= free_idx_d;
         oldest_idx_q <= oldest_idx_d;
         active_q     <= active_d;
         trigger_q    <= trigger_d;
         stolen_q     <= stolen_d;
         count_q      <= count_d;
         note_q       <= note_d;
         vel_q        <= vel_d;
         age_q        <= age_d;
      end
   end

   assign event_ready   = ready_q && !all_notes_off;
   assign voice_active  = active_q;
   assign voice_trigger = trigger_q;
   assign voice_stolen  = stolen_q;
   assign active_count  = count_q;

   always_comb begin
      voice_note     = '0;
      voice_velocity = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         voice_note[v*NOTE_WIDTH +: NOTE_WIDTH]             = note_q[v];
         voice_velocity[v*VELOCITY_WIDTH +: VELOCITY_WIDTH] = vel_q[v];
      end
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios followed by random note traffic,
// compared against a voice-list model ordered newest-first.
module tb_voice_allocator;

   localparam int NV = 8;
   localparam int NW = 7;
   localparam int VW = 7;
   localparam int CW = 4;

   logic              clk = 1'b0;
   logic              reset_l = 1'b0;
   logic              event_valid = 1'b0;
   logic              event_ready;
   logic              event_is_on = 1'b0;
   logic [NW-1:0]     event_note = '0;
   logic [VW-1:0]     event_velocity = '0;
   logic              all_notes_off = 1'b0;
   logic [NV-1:0]     voice_active;
   logic [NV*NW-1:0]  voice_note;
   logic [NV*VW-1:0]  voice_velocity;
   logic [NV-1:0]     voice_trigger;
   logic              voice_stolen;
   logic [CW-1:0]     active_count;

   int checks = 0;
   int errors = 0;

   bit            m_active [NV];
   int            m_note   [NV];
   int            m_vel    [NV];
   int            m_order  [$];
   logic [NV-1:0] exp_trig;
   logic          exp_stolen;

   voice_allocator #(
      .NUM_VOICES(NV),
      .NOTE_WIDTH(NW),
      .VELOCITY_WIDTH(VW)
   ) dut (
      .clock_50_000_000(clk),
      .reset_l(reset_l),
      .event_valid(event_valid),
      .event_ready(event_ready),
      .event_is_on(event_is_on),
      .event_note(event_note),
      .event_velocity(event_velocity),
      .all_notes_off(all_notes_off),
      .voice_active(voice_active),
      .voice_note(voice_note),
      .voice_velocity(voice_velocity),
      .voice_trigger(voice_trigger),
      .voice_stolen(voice_stolen),
      .active_count(active_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int find_match(input int note);
      for (int v = 0; v < NV; v++) begin
         if (m_active[v] && m_note[v] == note) return v;
      end
      return -1;
   endfunction

   function automatic void drop_order(input int v);
      for (int i = 0; i < m_order.size(); i++) begin
         if (m_order[i] == v) begin
            m_order.delete(i);
            return;
         end
      end
   endfunction

   function automatic void model_event(input bit on, input int note, input int vel);
      int m = find_match(note);
      int tgt;
      exp_trig   = '0;
      exp_stolen = 1'b0;
      if (on && vel != 0) begin
         if (m >= 0) begin
            tgt = m;
         end else begin
            tgt = -1;
            for (int v = NV - 1; v >= 0; v--) begin
               if (!m_active[v]) tgt = v;
            end
            if (tgt < 0) begin
               tgt        = m_order[$];
               exp_stolen = 1'b1;
            end
         end
         drop_order(tgt);
         m_order.push_front(tgt);
         m_active[tgt] = 1'b1;
         m_note[tgt]   = note;
         m_vel[tgt]    = vel;
         exp_trig[tgt] = 1'b1;
      end else if (m >= 0) begin
         m_active[m] = 1'b0;
         drop_order(m);
      end
   endfunction

   function automatic void model_clear(input bit full_reset);
      for (int v = 0; v < NV; v++) begin
         m_active[v] = 1'b0;
         if (full_reset) begin
            m_note[v] = 0;
            m_vel[v]  = 0;
         end
      end
      m_order.delete();
   endfunction

   task automatic checkOutput(input string tag);
      logic [NV-1:0]    a;
      logic [NV*NW-1:0] n;
      logic [NV*VW-1:0] vv;
      a  = '0;
      n  = '0;
      vv = '0;
      for (int v = 0; v < NV; v++) begin
         a[v]          = m_active[v];
         n[v*NW +: NW] = NW'(m_note[v]);
         vv[v*VW +: VW] = VW'(m_vel[v]);
      end
      check({tag, "/active"}, 64'(voice_active), 64'(a));
      check({tag, "/note"}, 64'(voice_note), 64'(n));
      check({tag, "/velocity"}, 64'(voice_velocity), 64'(vv));
      check({tag, "/count"}, 64'(active_count), 64'(m_order.size()));
      for (int i = 0; i < m_order.size(); i++) begin
         check({tag, "/age"}, 64'(dut.age_q[m_order[i]]), 64'(i));
      end
   endtask

   // Handshake one event, then follow it through LOOKUP and UPDATE.
   task automatic applyStimulus(input bit on, input int note, input int vel);
      int waited = 0;
      while (event_ready !== 1'b1 && waited < 16) begin
         @(posedge clk); #1;
         waited++;
      end
      check("ready_before_event", 64'(event_ready), 64'd1);
      event_valid    = 1'b1;
      event_is_on    = on;
      event_note     = NW'(note);
      event_velocity = VW'(vel);
      @(posedge clk); #1;
      event_valid    = 1'($urandom_range(0, 1));
      event_is_on    = 1'($urandom);
      event_note     = NW'($urandom);
      event_velocity = VW'($urandom);
      check("ready_low_cycle1", 64'(event_ready), 64'd0);
      @(posedge clk); #1;
      check("ready_low_cycle2", 64'(event_ready), 64'd0);
      @(posedge clk); #1;
      event_valid = 1'b0;
      model_event(on, note, vel);
      check("trigger_pulse", 64'(voice_trigger), 64'(exp_trig));
      check("stolen_pulse", 64'(voice_stolen), 64'(exp_stolen));
      check("ready_back", 64'(event_ready), 64'd1);
      checkOutput("event");
      @(posedge clk); #1;
      check("trigger_cleared", 64'(voice_trigger), 64'd0);
      check("stolen_cleared", 64'(voice_stolen), 64'd0);
   endtask

   task automatic panic_clear();
      all_notes_off = 1'b1;
      #1;
      check("panic_ready_low", 64'(event_ready), 64'd0);
      @(posedge clk); #1;
      all_notes_off = 1'b0;
      model_clear(1'b0);
      checkOutput("panic");
      check("panic_ready_still_low", 64'(event_ready), 64'd0);
      @(posedge clk); #1;
      check("panic_ready_back", 64'(event_ready), 64'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "/active"}, 64'(voice_active), 64'd0);
      check({tag, "/note"}, 64'(voice_note), 64'd0);
      check({tag, "/velocity"}, 64'(voice_velocity), 64'd0);
      check({tag, "/trigger"}, 64'(voice_trigger), 64'd0);
      check({tag, "/stolen"}, 64'(voice_stolen), 64'd0);
      check({tag, "/count"}, 64'(active_count), 64'd0);
      check({tag, "/ready"}, 64'(event_ready), 64'd0);
   endtask

   initial begin
      model_clear(1'b1);

      // Reset state and release mid-cycle.
      #3;
      check_all_zero("reset");
      @(posedge clk); #1;
      #16;
      reset_l = 1'b1;
      #1;
      check("ready_before_first_edge", 64'(event_ready), 64'd0);
      @(posedge clk); #1;
      check("ready_after_release", 64'(event_ready), 64'd1);

      // Single note-on lands in voice 0.
      applyStimulus(1'b1, 60, 100);
      check("first_note_voice0", 64'(voice_active), 64'h01);

      // Release of a middle voice, then reuse of the freed slot.
      applyStimulus(1'b1, 62, 90);
      applyStimulus(1'b1, 64, 80);
      applyStimulus(1'b0, 62, 0);
      check("release_mid_active", 64'(voice_active), 64'h05);
      check("release_mid_age0", 64'(dut.age_q[0]), 64'd1);
      check("release_mid_age2", 64'(dut.age_q[2]), 64'd0);
      applyStimulus(1'b1, 65, 70);
      check("reuse_voice1_note", 64'(voice_note[NW +: NW]), 64'd65);
      panic_clear();

      // Fill every voice, then steal the oldest.
      for (int n = 40; n < 48; n++) applyStimulus(1'b1, n, n + 10);
      applyStimulus(1'b1, 48, 33);
      check("steal_voice0_note", 64'(voice_note[0 +: NW]), 64'd48);
      check("steal_count_full", 64'(active_count), 64'd8);
      panic_clear();

      // Retrigger of the same note, then release via zero velocity.
      applyStimulus(1'b1, 60, 100);
      applyStimulus(1'b1, 60, 20);
      check("retrigger_single", 64'(active_count), 64'd1);
      applyStimulus(1'b1, 60, 0);
      check("vel0_release", 64'(voice_active), 64'd0);

      // Note-off for a note that never sounded.
      applyStimulus(1'b1, 30, 50);
      applyStimulus(1'b1, 31, 51);
      applyStimulus(1'b0, 70, 9);

      // Panic clear while an event sits in LOOKUP.
      event_valid    = 1'b1;
      event_is_on    = 1'b1;
      event_note     = NW'(12);
      event_velocity = VW'(99);
      @(posedge clk); #1;
      event_valid   = 1'b0;
      all_notes_off = 1'b1;
      @(posedge clk); #1;
      model_clear(1'b0);
      checkOutput("panic_lookup");
      check("panic_lookup_trigger", 64'(voice_trigger), 64'd0);
      check("panic_lookup_ready", 64'(event_ready), 64'd0);
      all_notes_off = 1'b0;
      #1;
      check("panic_lookup_ready_low", 64'(event_ready), 64'd0);
      @(posedge clk); #1;
      check("panic_lookup_ready_back", 64'(event_ready), 64'd1);
      check("panic_lookup_dropped", 64'(voice_active), 64'd0);
      check("panic_lookup_no_pulse", 64'(voice_trigger), 64'd0);

      // Reset asserted while an event is in UPDATE.
      applyStimulus(1'b1, 20, 21);
      event_valid    = 1'b1;
      event_is_on    = 1'b1;
      event_note     = NW'(50);
      event_velocity = VW'(77);
      @(posedge clk); #1;
      event_valid = 1'b0;
      @(posedge clk); #1;
      reset_l = 1'b0;
      #1;
      check_all_zero("reset_in_update");
      @(posedge clk); #1;
      #3;
      reset_l = 1'b1;
      @(posedge clk); #1;
      model_clear(1'b1);
      check("post_reset_trigger", 64'(voice_trigger), 64'd0);
      check("post_reset_ready", 64'(event_ready), 64'd1);
      checkOutput("post_reset");
      @(posedge clk); #1;
      check("post_reset_trigger2", 64'(voice_trigger), 64'd0);

      // Random traffic over a narrow note range to force matches and steals.
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            panic_clear();
         end else begin
            applyStimulus(($urandom_range(0, 3) != 0),
                          60 + int'($urandom_range(0, 11)),
                          ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127)));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
